// File: rtl/bullet_magazine_pkg.sv
// Shared game constants: magazine capacity (also used by the HUD renderer)
// and the magazine state encodings.
package bullet_magazine_pkg;

    localparam int GAME_MAX_BULLET = 6;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_RELOAD   = 2'd2
    } mag_state_e;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bullet_magazine_rise_detect.sv
// Rising-edge detector for an already-synchronised button level.
// History resets to 0, so a button held through reset counts as a fresh press.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/bullet_magazine.sv
// Magazine controller: tracks rounds, enforces shot cooldown and timed reload,
// and produces registered HUD/effect outputs.
module bullet_magazine
    import bullet_magazine_pkg::*;
#(
    parameter int MAX_BULLET      = GAME_MAX_BULLET,
    parameter int COOLDOWN_CYCLES = 5_000_000,
    parameter int RELOAD_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire_req,
    input  logic       reload_req,
    output logic [4:0] leftBullet,
    output logic       shot,
    output logic       dry_fire,
    output logic       reloading,
    output logic       empty
);

    localparam int CNT_MAX = max_cycles(COOLDOWN_CYCLES, RELOAD_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOAD_LOAD = CNT_W'(RELOAD_CYCLES - 1);
    localparam logic [4:0]       FULL        = 5'(MAX_BULLET);

    mag_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       left_q, left_d;
    logic             shot_q, shot_d;
    logic             dry_q, dry_d;
    logic             reloading_q, reloading_d;
    logic             empty_q, empty_d;
    logic             fire_ev;
    logic             reload_ev;

    rise_detect u_fire_edge (
        .clk   (clk),
        .reset (reset),
        .level (fire_req),
        .rise  (fire_ev)
    );

    rise_detect u_reload_edge (
        .clk   (clk),
        .reset (reset),
        .level (reload_req),
        .rise  (reload_ev)
    );

    // Events are only honoured in READY; fire wins over a simultaneous reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        shot_d  = 1'b0;
        dry_d   = 1'b0;
        case (state_q)
            ST_READY: begin
                if (fire_ev) begin
                    if (left_q != 5'd0) begin
                        left_d  = left_q - 5'd1;
                        shot_d  = 1'b1;
                        state_d = ST_COOLDOWN;
                        cnt_d   = COOL_LOAD;
                    end else begin
                        dry_d = 1'b1;
                    end
                end else if (reload_ev && (left_q != FULL)) begin
                    state_d = ST_RELOAD;
                    cnt_d   = RELOAD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELOAD: begin
                if (cnt_q == '0) begin
                    state_d = ST_READY;
                    left_d  = FULL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
        reloading_d = (state_d == ST_RELOAD);
        empty_d     = (left_d == 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_READY;
            cnt_q       <= '0;
            left_q      <= FULL;
            shot_q      <= 1'b0;
            dry_q       <= 1'b0;
            reloading_q <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            shot_q      <= shot_d;
            dry_q       <= dry_d;
            reloading_q <= reloading_d;
            empty_q     <= empty_d;
        end
    end

    assign leftBullet = left_q;
    assign shot       = shot_q;
    assign dry_fire   = dry_q;
    assign reloading  = reloading_q;
    assign empty      = empty_q;

endmodule
